register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
- Parametrised successor to the core's integer register file, for the pipelined core.
- Provides:
  - two combinational read ports;
  - one synchronous write port with write-to-read bypass;
  - hardwired-zero x0;
  - a pending-write scoreboard for hazard detection;
  - a registered debug read port;
  - a LED tap on a selectable register.
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers, 2..2^ADDR_WIDTH.
- ADDR_WIDTH, 5, register address width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the stored value.
- LED_REG, 15, index of the register driven to the LEDs.
- LED_WIDTH, 8, LED bus width, at most DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- regWrite  input  1  write enable, writeback stage.
- writeRegister  input  ADDR_WIDTH  write address.
- writeData  input  DATA_WIDTH  write data.
- readRegister1  input  ADDR_WIDTH  read port 1 address.
- readRegister2  input  ADDR_WIDTH  read port 2 address.
- readData1  output  DATA_WIDTH  read port 1 data, combinational.
- readData2  output  DATA_WIDTH  read port 2 data, combinational.
- issueValid  input  1  decode issued an instruction that will write issueRegister.
- issueRegister  input  ADDR_WIDTH  destination of the issued instruction.
- flush  input  1  pipeline flush; clears all pending bits.
- pending1  output  1  readRegister1 has an outstanding write.
- pending2  output  1  readRegister2 has an outstanding write.
- dbgRegister  input  ADDR_WIDTH  debug read address.
- dbgData  output  DATA_WIDTH  debug read data, registered.
- leds  output  LED_WIDTH  inverted low LED_WIDTH bits of register LED_REG.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, mid-operation included):
  - all registers = 0;
  - all pending bits = 0;
  - dbgData = 0;
  - leds = all ones (inverted zero).
  - Release is synchronous to clk.
- Write:
  - At the rising edge with regWrite=1, writeRegister != 0 and writeRegister < NUM_REGS, the register takes writeData.
  - A write to x0 or to an out-of-range address is ignored. No other state changes, including the other registers.
- Read, combinational:
  - Address 0 or address >= NUM_REGS returns 0.
  - BYPASS=1: if regWrite=1, writeRegister equals the read address, and the address is nonzero and in range, return writeData in the same cycle.
  - Otherwise return the stored value.
  - Both ports are independent; identical addresses are allowed.
- Scoreboard: one pending bit per register; bit 0 is constant 0.
  - Clear: at the edge with regWrite=1, the bit for writeRegister clears.
  - Set: at the edge with issueValid=1 and issueRegister nonzero and in range, the bit for issueRegister sets.
  - Same register cleared and set in one edge: set wins (a newer writer is outstanding).
  - flush=1 at an edge: all bits clear; flush overrides a simultaneous issue.
- pending1/pending2 report the current bit for the read address (0 for x0 or out of range).
  - BYPASS=1: a read address matching an active same-cycle write is reported not pending.
- dbgData: registered one cycle after dbgRegister is presented, taking the post-write value.
  - A write at edge N to the debug address appears on dbgData after edge N+1.
  - Address 0 or out of range yields 0.
- leds = ~register[LED_REG][LED_WIDTH-1:0], updated the cycle after the write. It is not bypassed.
- Latency:
  - reads: 0 cycles;
  - write visibility without bypass: 1 cycle;
  - scoreboard: 1 cycle;
  - debug: 1 cycle.

Test Plan:
- Reset and x0:
  - Stimulus: assert reset low mid-run after writing x5=0x1234, then release, read x5; then write x0=0xFFFFFFFF.
  - Response: readData1=0, leds=0xFF, dbgData=0; readData1 for x0 stays 0.
- Write/read and bypass:
  - Stimulus: regWrite=1, writeRegister=7, writeData=0xDEADBEEF, readRegister1=7, readRegister2=7 in the same cycle.
  - Response: both read ports return 0xDEADBEEF combinationally (BYPASS=1); with BYPASS=0 they return the old value until the next cycle.
- Scoreboard:
  - Stimulus: issue x3 at edge 1; read x3.
  - Response: pending1=1 from edge 1; writeback x3 at edge 4 clears it; pending1=0 after edge 4, and pending1=0 during edge-4's cycle because of the bypass.
- Simultaneous issue/writeback:
  - Stimulus: at one edge, regWrite to x9 plus issueValid to x9.
  - Response: x9 updated and pending stays 1.
  - Stimulus: the same plus flush=1.
  - Response: all pending bits 0.
- Out-of-range and LEDs:
  - Stimulus: with NUM_REGS=16, write x20; then write x15=0x000000A5.
  - Response: reads of x20 return 0 and pending of x20 stays 0; after the x15 write, leds=0x5A.
- Debug port:
  - Stimulus: dbgRegister=12 while writing x12=0x55.
  - Response: dbgData=0x55 one cycle after the write edge; dbgRegister=0 yields dbgData=0.

Source files
------------

// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//   Integer register file for the pipelined core, with a pending-write
//   scoreboard for hazard detection, a registered debug read port and an
//   LED tap on one register.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   regWrite       write enable (writeback stage)
//   writeRegister  write address
//   writeData      write data
//   readRegister1  read port 1 address
//   readRegister2  read port 2 address
//   readData1      read port 1 data (combinational)
//   readData2      read port 2 data (combinational)
//   issueValid     decode issued an instruction that will write issueRegister
//   issueRegister  destination of the issued instruction
//   flush          pipeline flush, clears every pending bit
//   pending1       readRegister1 has an outstanding write
//   pending2       readRegister2 has an outstanding write
//   dbgRegister    debug read address
//   dbgData        debug read data (registered, one cycle)
//   leds           inverted low LED_WIDTH bits of register LED_REG
// ---------------------------------------------------------------------------
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int LED_REG    = 15,
  parameter int LED_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  input  logic                  flush,
  output logic                  pending1,
  output logic                  pending2,
  input  logic [ADDR_WIDTH-1:0] dbgRegister,
  output logic [DATA_WIDTH-1:0] dbgData,
  output logic [LED_WIDTH-1:0]  leds
);

  // Every encodable address gets an entry in the views below; x0 and
  // addresses beyond NUM_REGS are tied to zero, so reads never need a
  // separate range check and never index past the real storage.
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] reg_view  [DEPTH];
  logic                  pend_view [DEPTH];
  logic [DATA_WIDTH-1:0] dbg_data_reg;
  logic                  write_en;
  logic                  bypass1;
  logic                  bypass2;

  function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < 32'(NUM_REGS));
  endfunction

  assign write_en = regWrite && addr_valid(writeRegister);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi != 0 && gi < NUM_REGS) begin : g_live
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  pend_reg;

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            data_reg <= '0;
            pend_reg <= 1'b0;
          end else begin
            if (write_en && writeRegister == IDX)
              data_reg <= writeData;
            // flush beats everything; a new issue beats a retiring write
            // because the newer writer is still outstanding.
            if (flush)
              pend_reg <= 1'b0;
            else if (issueValid && issueRegister == IDX)
              pend_reg <= 1'b1;
            else if (regWrite && writeRegister == IDX)
              pend_reg <= 1'b0;
          end
        end

        assign reg_view[gi]  = data_reg;
        assign pend_view[gi] = pend_reg;
      end else begin : g_zero
        assign reg_view[gi]  = '0;
        assign pend_view[gi] = 1'b0;
      end
    end
  endgenerate

  // write_en already implies a nonzero in-range address, so an address
  // match is enough to make the forward safe.
  assign bypass1 = (BYPASS != 0) && write_en && (writeRegister == readRegister1);
  assign bypass2 = (BYPASS != 0) && write_en && (writeRegister == readRegister2);

  assign readData1 = bypass1 ? writeData : reg_view[readRegister1];
  assign readData2 = bypass2 ? writeData : reg_view[readRegister2];

  // A forwarded read already has its value, so it is not a hazard.
  assign pending1 = bypass1 ? 1'b0 : pend_view[readRegister1];
  assign pending2 = bypass2 ? 1'b0 : pend_view[readRegister2];

  // Samples the stored (pre-edge) value: a write at edge N shows up
  // after edge N+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dbg_data_reg <= '0;
    else
      dbg_data_reg <= reg_view[dbgRegister];
  end

  assign dbgData = dbg_data_reg;
  assign leds    = ~reg_view[LED_REG][LED_WIDTH-1:0];

endmodule
